// File: rtl/dma_block_xfer_ctrl.sv
// Single-channel block DMA between external and internal data memory.
// The core arbitrates internal memory; one word is a RD/WR pair that cannot be split.
//
// state  | meaning
// IDLE   | waiting for start, configuration latched on start
// REQ    | requesting internal memory, waiting for grant
// RD     | source memory read select
// WR     | destination write of the word read in RD, pointers advance
// DONE   | single-cycle completion pulse
module dma_block_xfer_ctrl #(
   parameter int EXT_AW = 3,
   parameter int INT_AW = 3,
   parameter int DW     = 4,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              dir,
   input  logic [EXT_AW-1:0] ext_base,
   input  logic [INT_AW-1:0] int_base,
   input  logic [CNT_W-1:0]  count,
   output logic              dma_req,
   input  logic              dma_grant,
   output logic              busy,
   output logic              done,
   output logic              ext_cslt,
   output logic              ext_wrb,
   output logic [EXT_AW-1:0] ext_add,
   output logic [DW-1:0]     ext_wdt,
   input  logic [DW-1:0]     ext_rdt,
   output logic              int_cslt,
   output logic              int_wrb,
   output logic [INT_AW-1:0] int_add,
   output logic [DW-1:0]     int_wdt,
   input  logic [DW-1:0]     int_rdt
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_WR, S_DONE} state_t;

   state_t              state_q, state_d;
   logic                dir_q;
   logic [EXT_AW-1:0]   ext_ptr_q;
   logic [INT_AW-1:0]   int_ptr_q;
   logic [CNT_W-1:0]    remain_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         dir_q     <= 1'b0;
         ext_ptr_q <= '0;
         int_ptr_q <= '0;
         remain_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && start) begin
            dir_q     <= dir;
            ext_ptr_q <= ext_base;
            int_ptr_q <= int_base;
            remain_q  <= count;
         end else if (state_q == S_WR) begin
            ext_ptr_q <= ext_ptr_q + 1'b1;
            int_ptr_q <= int_ptr_q + 1'b1;
            remain_q  <= remain_q - 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      dma_req  = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      ext_cslt = 1'b0;
      ext_wrb  = 1'b0;
      ext_add  = '0;
      ext_wdt  = '0;
      int_cslt = 1'b0;
      int_wrb  = 1'b0;
      int_add  = '0;
      int_wdt  = '0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = (count == '0) ? S_DONE : S_REQ;
         end
         S_REQ: begin
            dma_req = 1'b1;
            busy    = 1'b1;
            if (dma_grant) state_d = S_RD;
         end
         S_RD: begin
            dma_req = 1'b1;
            busy    = 1'b1;
            if (!dir_q) begin
               ext_cslt = 1'b1;
               ext_add  = ext_ptr_q;
            end else begin
               int_cslt = 1'b1;
               int_add  = int_ptr_q;
            end
            state_d = S_WR;
         end
         S_WR: begin
            dma_req = 1'b1;
            busy    = 1'b1;
            // read data arrives the cycle after the select, so it is passed straight through
            if (!dir_q) begin
               int_cslt = 1'b1;
               int_wrb  = 1'b1;
               int_add  = int_ptr_q;
               int_wdt  = ext_rdt;
            end else begin
               ext_cslt = 1'b1;
               ext_wrb  = 1'b1;
               ext_add  = ext_ptr_q;
               ext_wdt  = int_rdt;
            end
            if (remain_q == CNT_W'(1)) state_d = S_DONE;
            else if (dma_grant)        state_d = S_RD;
            else                       state_d = S_REQ;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_dma_block_xfer_ctrl.sv
// Randomized scoreboard bench for dma_block_xfer_ctrl: expected destination writes are
// derived from the memory images and queued at start; a monitor pops them as writes appear.
module tb_dma_block_xfer_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       dir = 1'b0;
   logic [2:0] ext_base = '0;
   logic [2:0] int_base = '0;
   logic [3:0] count = '0;
   logic       dma_req;
   logic       dma_grant = 1'b0;
   logic       busy, done;
   logic       ext_cslt, ext_wrb, int_cslt, int_wrb;
   logic [2:0] ext_add, int_add;
   logic [3:0] ext_wdt, int_wdt;
   logic [3:0] ext_rdt = '0;
   logic [3:0] int_rdt = '0;

   logic [3:0] ext_mem [8];
   logic [3:0] int_mem [8];

   typedef struct {bit to_ext; int addr; int data;} wr_t;
   wr_t sb[$];

   int  vectors = 0;
   int  miscompares = 0;
   bit  prev_grant = 1'b0;

   dma_block_xfer_ctrl #(.EXT_AW(3), .INT_AW(3), .DW(4), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .dir(dir),
      .ext_base(ext_base), .int_base(int_base), .count(count),
      .dma_req(dma_req), .dma_grant(dma_grant), .busy(busy), .done(done),
      .ext_cslt(ext_cslt), .ext_wrb(ext_wrb), .ext_add(ext_add), .ext_wdt(ext_wdt), .ext_rdt(ext_rdt),
      .int_cslt(int_cslt), .int_wrb(int_wrb), .int_add(int_add), .int_wdt(int_wdt), .int_rdt(int_rdt)
   );

   always #5 clk = ~clk;

   // memory models: synchronous write, read data valid the cycle after the select
   always @(posedge clk) begin
      if (ext_cslt && ext_wrb) ext_mem[ext_add] = ext_wdt;
      if (int_cslt && int_wrb) int_mem[int_add] = int_wdt;
      ext_rdt <= (ext_cslt && !ext_wrb) ? ext_mem[ext_add] : 4'h0;
      int_rdt <= (int_cslt && !int_wrb) ? int_mem[int_add] : 4'h0;
   end

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (ext_cslt || int_cslt) check("one_select", int'(ext_cslt && int_cslt), 0);
      if ((ext_cslt && !ext_wrb) || (int_cslt && !int_wrb)) check("rd_after_grant", int'(prev_grant), 1);
      if ((ext_cslt && ext_wrb) || (int_cslt && int_wrb)) begin
         if (sb.size() == 0) begin
            check("unexpected_write", 1, 0);
         end else begin
            e = sb.pop_front();
            check("wr_mem_ext", int'(ext_cslt), int'(e.to_ext));
            check("wr_addr", ext_cslt ? int'(ext_add) : int'(int_add), e.addr);
            check("wr_data", ext_cslt ? int'(ext_wdt) : int'(int_wdt), e.data);
         end
      end
      prev_grant = dma_grant;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic int outs_vec();
      return int'({dma_req, busy, done, ext_cslt, ext_wrb, ext_add, ext_wdt,
                   int_cslt, int_wrb, int_add, int_wdt});
   endfunction

   // mode: 0 grant held, 1 random grant, 2 scripted stall, 3 start re-pulse, 4 reset mid-block
   task automatic run_block(input bit d, input int eb, input int ib, input int cnt,
                            input int mode, input int exp_done);
      int         n_push, done_cyc, busy_n;
      logic [2:0] sa, da;
      wr_t        e;
      n_push = (mode == 4) ? 1 : cnt;
      for (int i = 0; i < n_push; i++) begin
         sa = d ? 3'(ib + i) : 3'(eb + i);
         da = d ? 3'(eb + i) : 3'(ib + i);
         e.to_ext = d;
         e.addr   = int'(da);
         e.data   = d ? int'(int_mem[sa]) : int'(ext_mem[sa]);
         sb.push_back(e);
      end
      cyc();
      start     = 1'b1;
      dir       = d;
      ext_base  = 3'(eb);
      int_base  = 3'(ib);
      count     = 4'(cnt);
      dma_grant = (mode != 2);
      done_cyc  = -1;
      busy_n    = 0;
      for (int c = 1; c <= 200; c++) begin
         cyc();
         start = 1'b0;
         case (mode)
            1:       dma_grant = ($urandom_range(0, 3) != 0);
            2:       dma_grant = !(c <= 5 || c == 8);
            default: dma_grant = 1'b1;
         endcase
         if (mode == 3 && c == 3) begin
            start    = 1'b1;
            dir      = !d;
            ext_base = 3'(eb + 3);
            int_base = 3'(ib + 1);
            count    = 4'(cnt + 2);
         end
         if (mode == 4) reset = (c == 4 || c == 5);
         @(negedge clk);
         if (busy) busy_n++;
         if (mode == 2 && (c <= 6 || c == 9)) begin
            check("stall_no_select", int'(ext_cslt || int_cslt), 0);
            check("stall_req", int'(dma_req), 1);
         end
         if (cnt == 0) check("zero_no_activity", int'(dma_req || ext_cslt || int_cslt), 0);
         if (mode == 4 && c >= 5) begin
            check("reset_outputs_zero", outs_vec(), 0);
            if (c == 12) break;
         end
         if (done) begin
            done_cyc = c;
            check("busy_low_at_done", int'(busy), 0);
            break;
         end
      end
      if (mode == 4) begin
         check("reset_no_done", done_cyc, -1);
      end else begin
         check("done_seen", int'(done_cyc != -1), 1);
         if (exp_done >= 0) check("done_cycle", done_cyc, exp_done);
         if (done_cyc != -1) check("busy_cycles", busy_n, done_cyc - 1);
         cyc();
         @(negedge clk);
         check("after_done_idle", int'({done, busy, dma_req}), 0);
      end
      check("sb_empty", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      int d, eb, ib, cnt, mode, exp;
      for (int i = 0; i < 8; i++) begin
         ext_mem[i] = 4'($urandom);
         int_mem[i] = 4'($urandom);
      end
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      @(negedge clk);
      check("reset_state", outs_vec(), 0);

      ext_mem[2] = 4'hA;
      ext_mem[3] = 4'hB;
      ext_mem[4] = 4'hC;
      run_block(1'b0, 2, 5, 3, 0, 8);
      run_block(1'b1, 7, 6, 4, 0, 10);
      run_block(1'b0, 1, 1, 0, 0, 1);
      run_block(1'b0, 0, 3, 3, 2, 14);
      run_block(1'b1, 4, 2, 3, 3, 8);
      run_block(1'b0, 5, 0, 5, 4, -1);
      cyc();
      reset = 1'b0;

      for (int k = 0; k < 14; k++) begin
         for (int i = 0; i < 8; i++) begin
            ext_mem[i] = 4'($urandom);
            int_mem[i] = 4'($urandom);
         end
         d    = int'($urandom_range(0, 1));
         eb   = int'($urandom_range(0, 7));
         ib   = int'($urandom_range(0, 7));
         cnt  = int'($urandom_range(0, 15));
         mode = int'($urandom_range(0, 1));
         exp  = (cnt == 0) ? 1 : ((mode == 0) ? 2 * cnt + 2 : -1);
         run_block(d[0], eb, ib, cnt, mode, exp);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
